hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//  Hazard/forwarding controller for the 5-stage MIPS core; the partner of the execute stage.
//  Consumes the rs/rt register numbers that execute exports. Produces forwardAE/forwardBE
//  (consumed by execute's operand muxes), decode-stage branch forwarding, stall/flush controls
//  and a multicycle-op busy tracker. Also keeps saturating stall/flush performance counters.
// PARAMETERS
//  MD_LATENCY  4   cycles a multicycle (mul/div) op occupies E; legal range >= 2
//  CNT_W       32  width of the performance counters
// PORTS
//  clk                 in   1   core clock
//  rst                 in   1   synchronous, active-high reset
//  rsD, rtD            in   5   decode-stage source registers
//  branchD, jumpD      in   1   decode holds a branch / jump
//  pcSrcD              in   1   branch resolved taken in decode
//  rsE, rtE            in   5   execute-stage sources, from execute's hazard-unit outputs
//  writeRegE           in   5   execute destination register
//  regWriteE, memToRegE in  1   execute writes a register / is a load
//  mdStartE            in   1   execute issues a multicycle op this cycle
//  writeRegM           in   5   memory-stage destination register
//  regWriteM, memToRegM in  1   memory-stage writes a register / is a load
//  writeRegW           in   5   writeback destination register
//  regWriteW           in   1   writeback writes a register
//  forwardAE, forwardBE out 2   execute operand select: 00 reg file, 01 resultW, 10 aluOutM
//  forwardAD, forwardBD out 1   decode comparator takes aluOutM
//  stallF, stallD, stallE out 1 hold PC / IF-ID / ID-EX registers
//  flushD, flushE, flushM out 1 clear IF-ID / ID-EX / EX-MEM registers
//  mdBusy              out  1   multicycle op in flight
//  mdDone              out  1   one-cycle pulse on the last busy cycle
//  stallCount, flushCount out CNT_W  saturating performance counters
// BEHAVIOUR
//  - Register $0 is never a forwarding or hazard match.
//  - forwardAE = 10 if rsE!=0 && regWriteM && rsE==writeRegM.
//    Else 01 if rsE!=0 && regWriteW && rsE==writeRegW. Else 00.
//    The M stage has priority over W. forwardBE uses the same rule on rtE.
//  - forwardAD = rsD!=0 && regWriteM && rsD==writeRegM; forwardBD likewise on rtD.
//  - lwStall = memToRegE && rtE!=0 && (rtE==rsD || rtE==rtD).
//  - brStall = branchD && ((regWriteE && writeRegE!=0 && writeRegE in {rsD,rtD})
//    || (memToRegM && writeRegM!=0 && writeRegM in {rsD,rtD})).
//  - FSM, 2 states:
//    IDLE -> BUSY when mdStartE; the counter loads MD_LATENCY-2.
//    BUSY: the counter decrements each cycle. When counter==0, mdDone=1 and next state is IDLE.
//    mdBusy=1 in BUSY, so busy lasts MD_LATENCY-1 cycles after the issue cycle.
//    mdStartE is ignored while in BUSY (E is held).
//  - BUSY: stallF=stallD=stallE=1, flushM=1, flushE=0, flushD=0. Busy overrides lwStall/brStall.
//  - IDLE: stallF=stallD=lwStall|brStall, stallE=0, flushE=lwStall|brStall, flushM=0.
//  - IDLE: flushD = (pcSrcD|jumpD) && !stallD.
//  - A stalled branch resolves on a later cycle and only then flushes D.
//  - stallCount +1 on every cycle with stallF=1; flushCount +1 on every cycle with flushD|flushE.
//  - Both counters saturate at all-ones and never wrap.
//  - Reset:
//    FSM=IDLE, busy counter=0, mdBusy=0, mdDone=0, stallCount=0, flushCount=0.
//    While rst=1, all stall/flush outputs are 0.
//    Forward outputs stay purely combinational.
//  - Reset mid-BUSY aborts the op. The next cycle is IDLE with no mdDone pulse.
//  - All outputs except the counters, mdBusy and mdDone are combinational (0-cycle latency).
// STRUCTURE
//  - Package hazard_pkg: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; md_state_t {MD_IDLE, MD_BUSY}.
//  - One sub-module: md_stall_timer, which holds the FSM, the latency counter and mdBusy/mdDone.
//  - Forwarding, stall/flush logic and the counters stay in the top level.
// TESTING
//  - E/M/W chain: rsE=5, writeRegM=5, regWriteM=1 -> forwardAE=10.
//    Also set writeRegW=5, regWriteW=1 -> still 10.
//    Then regWriteM=0 -> 01. Then rsE=0 with everything matching -> 00.
//  - Load-use: memToRegE=1, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for exactly one cycle.
//    Next cycle (memToRegE=0) -> all 0. stallCount increments by 1.
//  - Branch: branchD=1, regWriteE=1, writeRegE=3, rtD=3 -> brStall for 1 cycle.
//    Then the M match gives forwardBD=1, no stall. pcSrcD=1 -> flushD=1.
//  - Multicycle, MD_LATENCY=4: mdStartE pulse -> mdBusy for 3 cycles.
//    stallF/D/E=1 and flushM=1 for those 3 cycles. mdDone on the 3rd. IDLE on the 4th.
//    A simultaneous lwStall during BUSY gives flushE=0.
//  - Reset mid-BUSY: rst during the 2nd busy cycle -> next cycle mdBusy=0, mdDone never
//    asserts, counters=0, stalls 0.
//  - Saturation: CNT_W=4, hold a stall for 20 cycles -> stallCount stops at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding controller: operand-select codes,
// multicycle-op FSM states and the common forwarding-select rule.
package hazard_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // M has priority over W: it holds the younger result of the same register.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] wr_m,
        input logic       rw_m,
        input logic [4:0] wr_w,
        input logic       rw_w
    );
        logic [1:0] sel;
        sel = FWD_REG;
        if (src != 5'd0 && rw_m && src == wr_m)
            sel = FWD_MEM;
        else if (src != 5'd0 && rw_w && src == wr_w)
            sel = FWD_WB;
        return sel;
    endfunction

endpackage

// File: rtl/md_stall_timer.sv
// Tracks a multicycle (mul/div) op occupying E: busy for MD_LATENCY-1 cycles
// after the issue cycle, with a done pulse on the last busy cycle.
//
//  state   | meaning
//  MD_IDLE | no multicycle op in flight; waiting for an issue
//  MD_BUSY | op occupies E; counter runs down to 0, then back to idle
module md_stall_timer
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_md_start,
    output logic o_md_busy,
    output logic o_md_done
);

    localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY - 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY - 2);

    md_state_t       r_state;
    md_state_t       w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Issue requests arriving while busy are dropped: E is held, so nothing new can issue.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            MD_IDLE: begin
                if (i_md_start) begin
                    w_state_nxt = MD_BUSY;
                    w_cnt_nxt   = LOAD_VAL;
                end
            end
            MD_BUSY: begin
                if (r_cnt == '0)
                    w_state_nxt = MD_IDLE;
                else
                    w_cnt_nxt = r_cnt - CW'(1);
            end
            default: begin
                w_state_nxt = MD_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A reset on the final busy cycle suppresses the done pulse (the op is aborted).
    always_comb begin
        o_md_busy = (r_state == MD_BUSY);
        o_md_done = (r_state == MD_BUSY) && (r_cnt == '0) && !i_rst;
    end

endmodule

// File: rtl/hazard_control_unit.sv
// Hazard/forwarding controller for the 5-stage core: operand forwarding, load-use and
// branch stalls, flushes, multicycle-op stalling and saturating stall/flush counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic             branchD,
    input  logic             jumpD,
    input  logic             pcSrcD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeRegE,
    input  logic             regWriteE,
    input  logic             memToRegE,
    input  logic             mdStartE,
    input  logic [4:0]       writeRegM,
    input  logic             regWriteM,
    input  logic             memToRegM,
    input  logic [4:0]       writeRegW,
    input  logic             regWriteW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             forwardAD,
    output logic             forwardBD,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             mdBusy,
    output logic             mdDone,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
);

    logic w_lw_stall;
    logic w_br_stall;
    logic w_hz_stall;
    logic w_br_e_hit;
    logic w_br_m_hit;
    logic w_md_busy;
    logic w_md_done;

    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    md_stall_timer #(
        .MD_LATENCY (MD_LATENCY)
    ) u_md_timer (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_md_start (mdStartE),
        .o_md_busy  (w_md_busy),
        .o_md_done  (w_md_done)
    );

    always_comb begin
        forwardAE = fwd_sel(rsE, writeRegM, regWriteM, writeRegW, regWriteW);
        forwardBE = fwd_sel(rtE, writeRegM, regWriteM, writeRegW, regWriteW);
        forwardAD = (rsD != 5'd0) && regWriteM && (rsD == writeRegM);
        forwardBD = (rtD != 5'd0) && regWriteM && (rtD == writeRegM);
    end

    // A branch compares in D, so it must wait for an ALU result still in E or a load still in M.
    always_comb begin
        w_lw_stall = memToRegE && (rtE != 5'd0) && ((rtE == rsD) || (rtE == rtD));
        w_br_e_hit = regWriteE && (writeRegE != 5'd0) &&
                     ((writeRegE == rsD) || (writeRegE == rtD));
        w_br_m_hit = memToRegM && (writeRegM != 5'd0) &&
                     ((writeRegM == rsD) || (writeRegM == rtD));
        w_br_stall = branchD && (w_br_e_hit || w_br_m_hit);
        w_hz_stall = w_lw_stall || w_br_stall;
    end

    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushM = 1'b0;
        if (rst) begin
            stallF = 1'b0;
        end else if (w_md_busy) begin
            // Busy freezes F/D/E and bubbles M; any pending hazard waits until idle.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
        end else begin
            stallF = w_hz_stall;
            stallD = w_hz_stall;
            flushE = w_hz_stall;
            flushD = (pcSrcD || jumpD) && !w_hz_stall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stallF && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((flushD || flushE) && (r_flush_cnt != '1))
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        mdBusy     = w_md_busy;
        mdDone     = w_md_done;
        stallCount = r_stall_cnt;
        flushCount = r_flush_cnt;
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: a table of single-cycle hazard vectors
// plus hand-written multicycle, reset and saturation sequences.
module tb_hazard_control_unit;

    localparam int MD_LATENCY = 4;
    localparam int CNT_W      = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rsD, rtD, rsE, rtE, writeRegE, writeRegM, writeRegW;
    logic             branchD, jumpD, pcSrcD;
    logic             regWriteE, memToRegE, mdStartE;
    logic             regWriteM, memToRegM, regWriteW;
    logic [1:0]       forwardAE, forwardBE;
    logic             forwardAD, forwardBD;
    logic             stallF, stallD, stallE, flushD, flushE, flushM;
    logic             mdBusy, mdDone;
    logic [CNT_W-1:0] stallCount, flushCount;

    int total = 0;
    int bad   = 0;

    hazard_control_unit #(
        .MD_LATENCY (MD_LATENCY),
        .CNT_W      (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rsD        (rsD),
        .rtD        (rtD),
        .branchD    (branchD),
        .jumpD      (jumpD),
        .pcSrcD     (pcSrcD),
        .rsE        (rsE),
        .rtE        (rtE),
        .writeRegE  (writeRegE),
        .regWriteE  (regWriteE),
        .memToRegE  (memToRegE),
        .mdStartE   (mdStartE),
        .writeRegM  (writeRegM),
        .regWriteM  (regWriteM),
        .memToRegM  (memToRegM),
        .writeRegW  (writeRegW),
        .regWriteW  (regWriteW),
        .forwardAE  (forwardAE),
        .forwardBE  (forwardBE),
        .forwardAD  (forwardAD),
        .forwardBD  (forwardBD),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushM     (flushM),
        .mdBusy     (mdBusy),
        .mdDone     (mdDone),
        .stallCount (stallCount),
        .flushCount (flushCount)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rsD;
        logic [4:0] rtD;
        logic       br;
        logic       jmp;
        logic       pcs;
        logic [4:0] rsE;
        logic [4:0] rtE;
        logic [4:0] wrE;
        logic       rwE;
        logic       mtrE;
        logic [4:0] wrM;
        logic       rwM;
        logic       mtrM;
        logic [4:0] wrW;
        logic       rwW;
        // expected {fAE,fBE,fAD,fBD,sF,sD,sE,fD,fE,fM}
        logic [13:0] exp;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic logic [13:0] outs();
        return {forwardAE, forwardBE, forwardAD, forwardBD,
                stallF, stallD, stallE, flushD, flushE, flushM};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rsD = 5'd0; rtD = 5'd0; branchD = 1'b0; jumpD = 1'b0; pcSrcD = 1'b0;
        rsE = 5'd0; rtE = 5'd0; writeRegE = 5'd0; regWriteE = 1'b0; memToRegE = 1'b0;
        mdStartE = 1'b0; writeRegM = 5'd0; regWriteM = 1'b0; memToRegM = 1'b0;
        writeRegW = 5'd0; regWriteW = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rsD = v.rsD; rtD = v.rtD; branchD = v.br; jumpD = v.jmp; pcSrcD = v.pcs;
        rsE = v.rsE; rtE = v.rtE; writeRegE = v.wrE; regWriteE = v.rwE; memToRegE = v.mtrE;
        writeRegM = v.wrM; regWriteM = v.rwM; memToRegM = v.mtrM;
        writeRegW = v.wrW; regWriteW = v.rwW; mdStartE = 1'b0;
    endtask

    initial begin
        //          rsD    rtD    br    jmp   pcs   rsE    rtE    wrE    rwE   mtrE  wrM    rwM   mtrM  wrW    rwW   expected
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_000_000};
        vecs[1]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 14'b10_00_0_0_000_000};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 14'b10_00_0_0_000_000};
        vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 14'b01_00_0_0_000_000};
        vecs[4]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 14'b00_00_0_0_000_000};
        vecs[5]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 14'b00_10_0_0_000_000};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 5'd7, 1'b1, 14'b00_01_0_0_000_000};
        vecs[7]  = '{5'd4, 5'd4, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 5'd0, 1'b0, 14'b00_00_1_1_000_000};
        vecs[8]  = '{5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_110_010};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_000_000};
        vecs[10] = '{5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_110_010};
        vecs[11] = '{5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_110_010};
        vecs[12] = '{5'd6, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 14'b00_00_1_0_110_010};
        vecs[13] = '{5'd0, 5'd3, 1'b1, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 14'b00_00_0_1_000_100};
        vecs[14] = '{5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_000_100};
        vecs[15] = '{5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_000_000};
        vecs[16] = '{5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 14'b00_00_0_0_000_000};
        vecs[17] = '{5'd6, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 5'd0, 1'b0, 14'b00_00_0_0_000_000};

        // Reset state: hazards present, yet stalls/flushes gated; forwarding stays live.
        clear_inputs();
        rst = 1'b1;
        memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8; pcSrcD = 1'b1;
        rsE = 5'd5; writeRegM = 5'd5; regWriteM = 1'b1;
        step();
        step();
        #2;
        chk("rst_stall_flush", 32'({stallF, stallD, stallE, flushD, flushE, flushM}), 32'd0);
        chk("rst_fwdAE", 32'(forwardAE), 32'(2'b10));
        chk("rst_counters", 32'({stallCount, flushCount}), 32'd0);
        chk("rst_md", 32'({mdBusy, mdDone}), 32'd0);
        clear_inputs();
        rst = 1'b0;
        step();

        // Table of single-cycle combinational vectors, one clock each.
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            #2;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
            step();
        end
        clear_inputs();
        #2;
        chk("table_stallCount", 32'(stallCount), 32'd4);
        chk("table_flushCount", 32'(flushCount), 32'd6);

        // Load-use: one stall cycle.
        do_reset();
        memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        #2;
        chk("lu_stall", 32'({stallF, stallD, flushE}), 32'b111);
        step();
        clear_inputs();
        #2;
        chk("lu_after", 32'(outs()), 32'd0);
        chk("lu_stallCount", 32'(stallCount), 32'd1);

        // Branch: E dependence stalls, then M forwarding resolves and flushes D.
        do_reset();
        branchD = 1'b1; regWriteE = 1'b1; writeRegE = 5'd3; rtD = 5'd3;
        #2;
        chk("br_stall", 32'({stallF, stallD, flushE, flushD, forwardBD}), 32'b11100);
        step();
        regWriteE = 1'b0; writeRegE = 5'd0; writeRegM = 5'd3; regWriteM = 1'b1; pcSrcD = 1'b1;
        #2;
        chk("br_resolve", 32'({stallF, flushE, flushD, forwardBD}), 32'b0011);
        step();
        clear_inputs();
        #2;
        chk("br_counts", 32'({stallCount, flushCount}), 32'({4'd1, 4'd2}));

        // Multicycle op: 3 busy cycles, done on the 3rd, lwStall masked, re-issue ignored.
        do_reset();
        mdStartE = 1'b1;
        #2;
        chk("md_issue", 32'({mdBusy, mdDone, stallF, stallE, flushM}), 32'd0);
        step();
        mdStartE = 1'b0;
        #2;
        chk("md_b1", 32'({mdBusy, mdDone, stallF, stallD, stallE, flushM, flushE, flushD}), 32'b10111100);
        step();
        memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8; mdStartE = 1'b1;
        #2;
        chk("md_b2_lw", 32'({mdBusy, mdDone, stallF, stallD, stallE, flushM, flushE, flushD}), 32'b10111100);
        step();
        clear_inputs();
        #2;
        chk("md_b3_done", 32'({mdBusy, mdDone, stallF, stallD, stallE, flushM, flushE}), 32'b1111110);
        step();
        #2;
        chk("md_idle", 32'({mdBusy, mdDone, stallF, stallD, stallE, flushM}), 32'd0);
        chk("md_counts", 32'({stallCount, flushCount}), 32'({4'd3, 4'd0}));
        step();

        // Reset during the 2nd busy cycle aborts the op.
        do_reset();
        mdStartE = 1'b1;
        step();
        mdStartE = 1'b0;
        step();
        rst = 1'b1;
        #2;
        chk("rb_in_rst", 32'({mdDone, stallF, stallD, stallE, flushM}), 32'd0);
        step();
        rst = 1'b0;
        #2;
        chk("rb_after", 32'({mdBusy, mdDone, stallF, stallE, flushM, stallCount, flushCount}), 32'd0);
        begin
            int seen_done;
            seen_done = 0;
            for (int k = 0; k < 4; k++) begin
                step();
                if (mdDone || mdBusy) seen_done++;
            end
            chk("rb_no_done", 32'(seen_done), 32'd0);
        end

        // Saturation: 20 stall cycles on a 4-bit counter.
        do_reset();
        memToRegE = 1'b1; rtE = 5'd8; rsD = 5'd8;
        for (int k = 0; k < 14; k++) step();
        #2;
        chk("sat_14", 32'(stallCount), 32'd14);
        for (int k = 0; k < 6; k++) step();
        #2;
        chk("sat_stall", 32'(stallCount), 32'd15);
        chk("sat_flush", 32'(flushCount), 32'd15);
        clear_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
